// File: rtl/axi4_sram_guard_if.sv
// AXI4 bundle shared by the SRAM guard and its neighbours.
// Widths come from the AXI4_* macros so every user agrees on them.
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 64
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH 1
`endif

interface axi4_if #(
  parameter int ADDR_W = `AXI4_ADDR_WIDTH,
  parameter int DATA_W = `AXI4_DATA_WIDTH,
  parameter int ID_W   = `AXI4_ID_WIDTH,
  parameter int USER_W = `AXI4_USER_WIDTH
) ();
  logic aclk;
  logic aresetn;

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic [3:0]          awregion;
  logic [USER_W-1:0]   awuser;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic [USER_W-1:0]   wuser;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic [USER_W-1:0]   buser;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic [3:0]          arregion;
  logic [USER_W-1:0]   aruser;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic [USER_W-1:0]   ruser;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock,
    output awcache, awprot, awqos, awregion, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock,
    output arcache, arprot, arqos, arregion, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock,
    input  awcache, awprot, awqos, awregion, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock,
    input  arcache, arprot, arqos, arregion, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_sram_guard.sv
// Front-end guard for axi4_sram: forwards legal in-window bursts,
// answers illegal/out-of-window ones locally, one transaction at a time.
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 64
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif

module axi4_sram_guard #(
  parameter int SRAM_WORD_DEPTH = 512,
  parameter int SRAM_BLOCK_SIZE = 4,
  parameter logic [`AXI4_ADDR_WIDTH-1:0] SRAM_BASE_ADDR = 32'h0F00_0000
) (
  input  logic  aclk,
  input  logic  aresetn,
  axi4_if.slave  s_axi,
  axi4_if.master m_axi
);
  localparam int AW  = `AXI4_ADDR_WIDTH;
  localparam int DW  = `AXI4_DATA_WIDTH;
  localparam int IW  = `AXI4_ID_WIDTH;
  localparam int NB  = DW / 8;
  localparam int NBL = $clog2(NB);
  localparam int SZ  = SRAM_WORD_DEPTH * SRAM_BLOCK_SIZE * NB;

  localparam logic [AW:0] BASE = {1'b0, SRAM_BASE_ADDR};
  localparam logic [AW:0] SIZE = (AW+1)'(SZ);
  localparam logic [AW:0] TOP  = BASE + SIZE - 1'b1;

  typedef enum logic [2:0] {
    IDLE, FWD_RD, FWD_WR, ERR_RD, ERR_WR, ERR_B
  } state_t;

  state_t          state;
  logic [IW-1:0]   err_id;
  logic [7:0]      err_len;
  logic [7:0]      cnt;
  logic [1:0]      err_resp;

  // One extra address bit keeps the window arithmetic overflow-free.
  function automatic logic [1:0] decode(
    input logic [AW-1:0] addr,
    input logic [7:0]    len,
    input logic [1:0]    burst
  );
    logic [AW:0] a;
    logic [AW:0] last;
    logic        wrap_ok;
    a       = {1'b0, addr};
    last    = {1'b0, addr & ~AW'(NB-1)} + ((AW+1)'(len) << NBL);
    wrap_ok = (len == 8'd1) || (len == 8'd3) ||
              (len == 8'd7) || (len == 8'd15);
    if (burst == 2'b11 || (burst == 2'b10 && !wrap_ok))
      decode = 2'b10;
    else if (a < BASE || a > TOP || (burst == 2'b01 && last > TOP))
      decode = 2'b11;
    else
      decode = 2'b00;
  endfunction

  logic [1:0] ar_resp, aw_resp;
  logic       idle, ar_fwd, ar_err, aw_fwd, aw_err;
  logic       r_fwd, r_err, w_fwd, w_drop, b_fwd, b_err;

  assign ar_resp = decode(s_axi.araddr, s_axi.arlen, s_axi.arburst);
  assign aw_resp = decode(s_axi.awaddr, s_axi.awlen, s_axi.awburst);

  assign idle   = aresetn && state == IDLE;
  assign ar_fwd = idle && s_axi.arvalid && ar_resp == 2'b00;
  assign ar_err = idle && s_axi.arvalid && ar_resp != 2'b00;
  assign aw_fwd = idle && !s_axi.arvalid && s_axi.awvalid &&
                  aw_resp == 2'b00;
  assign aw_err = idle && !s_axi.arvalid && s_axi.awvalid &&
                  aw_resp != 2'b00;
  assign r_fwd  = aresetn && state == FWD_RD;
  assign r_err  = aresetn && state == ERR_RD;
  assign b_fwd  = aresetn && state == FWD_WR;
  assign b_err  = aresetn && state == ERR_B;
  assign w_fwd  = aw_fwd || b_fwd;
  assign w_drop = aw_err || (aresetn && state == ERR_WR);

  always_comb begin
    m_axi.arid     = '0;
    m_axi.araddr   = '0;
    m_axi.arlen    = '0;
    m_axi.arsize   = '0;
    m_axi.arburst  = '0;
    m_axi.arlock   = '0;
    m_axi.arcache  = '0;
    m_axi.arprot   = '0;
    m_axi.arqos    = '0;
    m_axi.arregion = '0;
    m_axi.aruser   = '0;
    m_axi.arvalid  = 1'b0;
    m_axi.awid     = '0;
    m_axi.awaddr   = '0;
    m_axi.awlen    = '0;
    m_axi.awsize   = '0;
    m_axi.awburst  = '0;
    m_axi.awlock   = '0;
    m_axi.awcache  = '0;
    m_axi.awprot   = '0;
    m_axi.awqos    = '0;
    m_axi.awregion = '0;
    m_axi.awuser   = '0;
    m_axi.awvalid  = 1'b0;
    m_axi.wdata    = '0;
    m_axi.wstrb    = '0;
    m_axi.wlast    = 1'b0;
    m_axi.wuser    = '0;
    m_axi.wvalid   = 1'b0;
    m_axi.rready   = r_fwd & s_axi.rready;
    m_axi.bready   = b_fwd & s_axi.bready;
    if (ar_fwd) begin
      m_axi.arid     = s_axi.arid;
      m_axi.araddr   = s_axi.araddr;
      m_axi.arlen    = s_axi.arlen;
      m_axi.arsize   = s_axi.arsize;
      m_axi.arburst  = s_axi.arburst;
      m_axi.arlock   = s_axi.arlock;
      m_axi.arcache  = s_axi.arcache;
      m_axi.arprot   = s_axi.arprot;
      m_axi.arqos    = s_axi.arqos;
      m_axi.arregion = s_axi.arregion;
      m_axi.aruser   = s_axi.aruser;
      m_axi.arvalid  = 1'b1;
    end
    if (aw_fwd) begin
      m_axi.awid     = s_axi.awid;
      m_axi.awaddr   = s_axi.awaddr;
      m_axi.awlen    = s_axi.awlen;
      m_axi.awsize   = s_axi.awsize;
      m_axi.awburst  = s_axi.awburst;
      m_axi.awlock   = s_axi.awlock;
      m_axi.awcache  = s_axi.awcache;
      m_axi.awprot   = s_axi.awprot;
      m_axi.awqos    = s_axi.awqos;
      m_axi.awregion = s_axi.awregion;
      m_axi.awuser   = s_axi.awuser;
      m_axi.awvalid  = 1'b1;
    end
    if (w_fwd) begin
      m_axi.wdata  = s_axi.wdata;
      m_axi.wstrb  = s_axi.wstrb;
      m_axi.wlast  = s_axi.wlast;
      m_axi.wuser  = s_axi.wuser;
      m_axi.wvalid = s_axi.wvalid;
    end
  end

  always_comb begin
    s_axi.arready = ar_fwd ? m_axi.arready : ar_err;
    s_axi.awready = aw_fwd ? m_axi.awready : aw_err;
    s_axi.wready  = w_fwd ? m_axi.wready : w_drop;
    s_axi.rid     = '0;
    s_axi.rdata   = '0;
    s_axi.rresp   = '0;
    s_axi.rlast   = 1'b0;
    s_axi.ruser   = '0;
    s_axi.rvalid  = 1'b0;
    s_axi.bid     = '0;
    s_axi.bresp   = '0;
    s_axi.buser   = '0;
    s_axi.bvalid  = 1'b0;
    if (r_fwd) begin
      s_axi.rid    = m_axi.rid;
      s_axi.rdata  = m_axi.rdata;
      s_axi.rresp  = m_axi.rresp;
      s_axi.rlast  = m_axi.rlast;
      s_axi.rvalid = m_axi.rvalid;
    end
    if (r_err) begin
      s_axi.rid    = err_id;
      s_axi.rresp  = err_resp;
      s_axi.rlast  = cnt == err_len;
      s_axi.rvalid = 1'b1;
    end
    if (b_fwd) begin
      s_axi.bid    = m_axi.bid;
      s_axi.bresp  = m_axi.bresp;
      s_axi.bvalid = m_axi.bvalid;
    end
    if (b_err) begin
      s_axi.bid    = err_id;
      s_axi.bresp  = err_resp;
      s_axi.bvalid = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      err_id   <= '0;
      err_len  <= '0;
      err_resp <= '0;
      cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (s_axi.arvalid) begin
            if (ar_resp == 2'b00) begin
              if (m_axi.arready) state <= FWD_RD;
            end else begin
              err_id   <= s_axi.arid;
              err_len  <= s_axi.arlen;
              err_resp <= ar_resp;
              cnt      <= '0;
              state    <= ERR_RD;
            end
          end else if (s_axi.awvalid) begin
            if (aw_resp == 2'b00) begin
              if (m_axi.awready) state <= FWD_WR;
            end else begin
              err_id   <= s_axi.awid;
              err_resp <= aw_resp;
              // The only W beat may ride along with the error AW.
              state <= (s_axi.wvalid && s_axi.wlast) ? ERR_B : ERR_WR;
            end
          end
        end
        FWD_RD: begin
          if (m_axi.rvalid && s_axi.rready && m_axi.rlast)
            state <= IDLE;
        end
        FWD_WR: begin
          if (m_axi.bvalid && s_axi.bready) state <= IDLE;
        end
        ERR_RD: begin
          if (s_axi.rready) begin
            cnt <= cnt + 8'd1;
            if (cnt == err_len) state <= IDLE;
          end
        end
        ERR_WR: begin
          if (s_axi.wvalid && s_axi.wlast) state <= ERR_B;
        end
        ERR_B: begin
          if (s_axi.bready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_sram_guard.sv
// Directed plus random bench for axi4_sram_guard; the bench plays
// both the upstream master and a simple downstream SRAM responder.
module tb_axi4_sram_guard;
  logic clk;
  logic rst_n;
  int   cmp;
  int   bad;

  axi4_if s_if ();
  axi4_if m_if ();

  assign s_if.aclk    = clk;
  assign s_if.aresetn = rst_n;
  assign m_if.aclk    = clk;
  assign m_if.aresetn = rst_n;

  axi4_sram_guard dut (
    .aclk    (clk),
    .aresetn (rst_n),
    .s_axi   (s_if),
    .m_axi   (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Expected response computed straight from the window/burst rules.
  function automatic logic [1:0] exp_resp(input longint addr,
                                           input int len,
                                           input int burst);
    longint lo;
    longint hi;
    lo = 64'h0F00_0000;
    hi = lo + 512 * 4 * 8 - 1;
    if (burst == 3) return 2'b10;
    if (burst == 2 && len != 1 && len != 3 && len != 7 && len != 15)
      return 2'b10;
    if (addr < lo || addr > hi) return 2'b11;
    if (burst == 1 && (addr / 8) * 8 + len * 8 > hi) return 2'b11;
    return 2'b00;
  endfunction

  task automatic init_sigs();
    s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0;
    s_if.awsize = '0; s_if.awburst = '0; s_if.awlock = '0;
    s_if.awcache = '0; s_if.awprot = '0; s_if.awqos = '0;
    s_if.awregion = '0; s_if.awuser = '0; s_if.awvalid = 0;
    s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 0;
    s_if.wuser = '0; s_if.wvalid = 0; s_if.bready = 0;
    s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0;
    s_if.arsize = '0; s_if.arburst = '0; s_if.arlock = '0;
    s_if.arcache = '0; s_if.arprot = '0; s_if.arqos = '0;
    s_if.arregion = '0; s_if.aruser = '0; s_if.arvalid = 0;
    s_if.rready = 0;
    m_if.awready = 0; m_if.wready = 0; m_if.arready = 0;
    m_if.bid = '0; m_if.bresp = '0; m_if.buser = '0;
    m_if.bvalid = 0;
    m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0;
    m_if.rlast = 0; m_if.ruser = '0; m_if.rvalid = 0;
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr,
                    input logic [7:0] len, input logic [1:0] burst,
                    input int stall, input bit aw_held);
    logic [1:0]  e;
    logic [63:0] d;
    e = exp_resp(addr, len, burst);
    @(negedge clk);
    s_if.arvalid = 1; s_if.arid = id; s_if.araddr = addr;
    s_if.arlen = len; s_if.arburst = burst; s_if.arsize = 3'd3;
    m_if.arready = 1;
    #1;
    chk("ar_fwd_valid", m_if.arvalid, e == 2'b00);
    chk("ar_ready", s_if.arready, 1);
    if (e == 2'b00) begin
      chk("ar_addr", m_if.araddr, addr);
      chk("ar_id", m_if.arid, id);
      chk("ar_len", m_if.arlen, len);
    end
    if (aw_held) chk("aw_stall_ar", s_if.awready, 0);
    @(negedge clk);
    s_if.arvalid = 0; m_if.arready = 0;
    for (int b = 0; b <= int'(len); b++) begin
      d = {$urandom, $urandom};
      if (e == 2'b00) begin
        m_if.rvalid = 1; m_if.rid = id; m_if.rdata = d;
        m_if.rresp = 2'b00; m_if.rlast = (b == int'(len));
      end
      if (b == 0 && stall > 0) begin
        s_if.rready = 0;
        for (int k = 0; k < stall; k++) begin
          #1;
          chk("r_hold_valid", s_if.rvalid, 1);
          chk("r_hold_resp", s_if.rresp, e);
          chk("r_hold_last", s_if.rlast, len == 8'd0);
          @(negedge clk);
        end
      end
      s_if.rready = 1;
      #1;
      chk("r_valid", s_if.rvalid, 1);
      chk("r_id", s_if.rid, id);
      chk("r_data", s_if.rdata, (e == 2'b00) ? d : 64'd0);
      chk("r_resp", s_if.rresp, e);
      chk("r_last", s_if.rlast, b == int'(len));
      chk("r_user", s_if.ruser, 0);
      if (aw_held) begin
        chk("aw_stall_m", m_if.awvalid, 0);
        chk("aw_stall_s", s_if.awready, 0);
      end
      @(negedge clk);
    end
    s_if.rready = 0; m_if.rvalid = 0; m_if.rlast = 0;
    #1;
    chk("r_idle", s_if.rvalid, 0);
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] addr,
                    input logic [7:0] len, input logic [1:0] burst,
                    input int bstall, input bit first_w);
    logic [1:0]  e;
    logic [63:0] d;
    e = exp_resp(addr, len, burst);
    @(negedge clk);
    s_if.awvalid = 1; s_if.awid = id; s_if.awaddr = addr;
    s_if.awlen = len; s_if.awburst = burst; s_if.awsize = 3'd3;
    m_if.awready = 1; m_if.wready = 1;
    if (first_w) begin
      s_if.wvalid = 1; s_if.wlast = (len == 8'd0);
      s_if.wdata = {$urandom, $urandom};
    end
    #1;
    chk("aw_fwd_valid", m_if.awvalid, e == 2'b00);
    chk("aw_ready", s_if.awready, 1);
    if (e == 2'b00) begin
      chk("aw_addr", m_if.awaddr, addr);
      chk("aw_id", m_if.awid, id);
    end
    if (first_w && e != 2'b00) begin
      chk("w0_drop", m_if.wvalid, 0);
      chk("w0_ready", s_if.wready, 1);
    end
    @(negedge clk);
    s_if.awvalid = 0; m_if.awready = 0;
    for (int b = first_w ? 1 : 0; b <= int'(len); b++) begin
      d = {$urandom, $urandom};
      s_if.wvalid = 1; s_if.wdata = d; s_if.wlast = (b == int'(len));
      #1;
      chk("w_ready", s_if.wready, 1);
      chk("w_fwd", m_if.wvalid, e == 2'b00);
      if (e == 2'b00) chk("w_data", m_if.wdata, d);
      @(negedge clk);
    end
    s_if.wvalid = 0; s_if.wlast = 0;
    if (e == 2'b00) begin
      m_if.bvalid = 1; m_if.bid = id; m_if.bresp = 2'b00;
    end
    for (int k = 0; k < bstall; k++) begin
      #1;
      chk("b_hold_valid", s_if.bvalid, 1);
      chk("b_hold_resp", s_if.bresp, e);
      @(negedge clk);
    end
    s_if.bready = 1;
    #1;
    chk("b_valid", s_if.bvalid, 1);
    chk("b_id", s_if.bid, id);
    chk("b_resp", s_if.bresp, e);
    @(negedge clk);
    s_if.bready = 0; m_if.bvalid = 0; m_if.wready = 0;
    #1;
    chk("b_idle", s_if.bvalid, 0);
  endtask

  initial begin
    logic [31:0] a;
    cmp = 0;
    bad = 0;
    rst_n = 0;
    init_sigs();
    s_if.arvalid = 1; s_if.araddr = 32'h0F00_0100; s_if.arburst = 2'b01;
    m_if.arready = 1;
    #1;
    chk("rst_m_arvalid", m_if.arvalid, 0);
    chk("rst_s_arready", s_if.arready, 0);
    chk("rst_s_rvalid", s_if.rvalid, 0);
    chk("rst_s_bvalid", s_if.bvalid, 0);
    repeat (3) @(negedge clk);
    s_if.arvalid = 0; m_if.arready = 0;
    rst_n = 1;

    rd(4'd5, 32'h0F00_0100, 8'd3, 2'b01, 0, 0);
    rd(4'd2, 32'h0EFF_FFF8, 8'd1, 2'b01, 3, 0);
    wr(4'd7, 32'h0F00_3FF0, 8'd3, 2'b01, 0, 0);
    rd(4'd9, 32'h0F00_0000, 8'd2, 2'b10, 0, 0);
    rd(4'd4, 32'h0F00_0040, 8'd3, 2'b10, 0, 0);
    rd(4'd1, 32'h0F00_3FF8, 8'd0, 2'b01, 0, 0);
    rd(4'd1, 32'h0F00_4000, 8'd0, 2'b01, 0, 0);
    rd(4'd6, 32'hFFFF_FFF8, 8'd15, 2'b01, 0, 0);
    rd(4'd8, 32'h0F00_0000, 8'd0, 2'b11, 0, 0);
    wr(4'd3, 32'h0E00_0000, 8'd0, 2'b01, 2, 1);
    wr(4'd2, 32'h0F00_0200, 8'd2, 2'b01, 1, 0);

    // AR and AW together: read goes first, write waits.
    s_if.awvalid = 1; s_if.awid = 4'd11; s_if.awaddr = 32'h0F00_0800;
    s_if.awlen = 8'd1; s_if.awburst = 2'b01;
    rd(4'd10, 32'h0F00_0400, 8'd2, 2'b01, 0, 1);
    chk("aw_after_rd", m_if.awvalid, 1);
    wr(4'd11, 32'h0F00_0800, 8'd1, 2'b01, 0, 0);

    // Reset in the middle of an error read burst.
    @(negedge clk);
    s_if.arvalid = 1; s_if.arid = 4'd12; s_if.araddr = 32'h0EFF_0000;
    s_if.arlen = 8'd7; s_if.arburst = 2'b01;
    #1;
    chk("mid_ar_ready", s_if.arready, 1);
    @(negedge clk);
    s_if.arvalid = 0; s_if.rready = 1;
    #1;
    chk("mid_beat0", s_if.rvalid, 1);
    @(negedge clk);
    #1;
    chk("mid_beat1_last", s_if.rlast, 0);
    rst_n = 0;
    s_if.arvalid = 1; s_if.araddr = 32'h0F00_0000; s_if.arlen = 8'd0;
    m_if.arready = 1;
    #1;
    chk("async_rvalid", s_if.rvalid, 0);
    chk("async_m_arvalid", m_if.arvalid, 0);
    chk("async_s_arready", s_if.arready, 0);
    @(negedge clk);
    s_if.arvalid = 0; s_if.rready = 0; m_if.arready = 0;
    rst_n = 1;
    #1;
    chk("post_rst_rvalid", s_if.rvalid, 0);
    rd(4'd13, 32'h0F00_1000, 8'd1, 2'b01, 0, 0);

    for (int i = 0; i < 24; i++) begin
      a = 32'h0F00_0000 - 32'd64 + 32'($urandom_range(0, 16384 + 128));
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'd0;
      if ($urandom_range(0, 1) == 1)
        rd(4'($urandom), a, 8'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), $urandom_range(0, 2), 0);
      else
        wr(4'($urandom), a, 8'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), $urandom_range(0, 2), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
